// File: rtl/phase_enc_pkg.sv
// Shared types and sizes for the washing-machine phase-bus encoder.
package phase_enc_pkg;

    localparam int LINES  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {IDLE, SETTLE, PEND} enc_state_t;
    typedef logic [CODE_W-1:0] phase_code_t;

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational decode of the phase lines into a code plus none/legal/multi flags.
// PHASE_ENC_PRIORITY_EN: multi-hot patterns resolve to the highest set bit and count as legal.
module onehot_to_bin
    import phase_enc_pkg::*;
(
    input  logic [LINES-1:0] d,
    output phase_code_t      code,
    output logic             legal,
    output logic             none,
    output logic             multi
);

    localparam logic [LINES-1:0] ONE_L = LINES'(1);

    logic several;

    // Ascending scan leaves the highest set bit, which is also the only bit for a one-hot input.
    always_comb begin
        code = '0;
        for (int i = 0; i < LINES; i++) begin
            if (d[i]) code = phase_code_t'(i);
        end
    end

    assign none    = (d == '0);
    assign several = |(d & (d - ONE_L));

`ifdef PHASE_ENC_PRIORITY_EN
    assign multi = 1'b0;
    assign legal = !none;
`else
    assign multi = several;
    assign legal = !none && !several;
`endif

endmodule

// File: rtl/phase_enc.sv
// Phase-bus encoder: glitch filter, change-once reporting over valid/ready, sticky err, event count.
// PHASE_ENC_PRIORITY_EN: multi-hot input is legal (highest bit wins), err tied low, err_clr ignored.
module phase_enc
    import phase_enc_pkg::*;
#(
    parameter int STABLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LINES-1:0]  D,
    input  logic              ready,
    input  logic              err_clr,
    output logic [CODE_W-1:0] S,
    output logic              valid,
    output logic              err,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam int          CW       = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    phase_code_t code, cand, cand_nxt, last_code, last_nxt, s_nxt, pend_code;
    logic        legal, none, multi;
    enc_state_t  state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             have_last, have_last_nxt, valid_nxt, load_pend;
    logic [CNT_W-1:0] evt_nxt;

    onehot_to_bin u_dec (
        .d     (D),
        .code  (code),
        .legal (legal),
        .none  (none),
        .multi (multi)
    );

    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        s_nxt         = S;
        valid_nxt     = valid;
        last_nxt      = last_code;
        have_last_nxt = have_last;
        evt_nxt       = evt_cnt;
        load_pend     = 1'b0;
        pend_code     = cand;
        case (state)
            IDLE: begin
                if (legal && (!have_last || code != last_code)) begin
                    cand_nxt = code;
                    cnt_nxt  = CNT_ONE;
                    if (STABLE_CYC == 1) begin
                        load_pend = 1'b1;
                        pend_code = code;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (legal && code == cand) begin
                    if (cnt == CNT_LAST) load_pend = 1'b1;
                    else                 cnt_nxt   = cnt + CNT_ONE;
                end else if (legal) begin
                    cand_nxt = code;
                    cnt_nxt  = CNT_ONE;
                end else if (none || multi) begin
                    state_nxt = IDLE;
                end
            end
            PEND: begin
                if (ready) begin
                    valid_nxt = 1'b0;
                    evt_nxt   = sat_inc(evt_cnt);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Entering PEND latches the code on the same edge it qualifies.
        if (load_pend) begin
            state_nxt     = PEND;
            s_nxt         = pend_code;
            valid_nxt     = 1'b1;
            last_nxt      = pend_code;
            have_last_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            S         <= '0;
            valid     <= 1'b0;
            last_code <= '0;
            have_last <= 1'b0;
            evt_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            S         <= s_nxt;
            valid     <= valid_nxt;
            last_code <= last_nxt;
            have_last <= have_last_nxt;
            evt_cnt   <= evt_nxt;
        end
    end

`ifdef PHASE_ENC_PRIORITY_EN
    logic unused_err_in;
    assign unused_err_in = err_clr ^ multi;
    assign err = 1'b0;
`else
    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     err <= 1'b0;
        else if (multi)   err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_phase_enc.sv
// Self-checking bench for phase_enc: vector table, hand sequences, randomized run against a streak model.
module tb_phase_enc;

    localparam int STABLE  = 2;
    localparam int CW      = 2;
    localparam int EVT_MAX = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    D = 8'h00;
    logic          ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [2:0]    S;
    logic          valid;
    logic          err;
    logic [CW-1:0] evt_cnt;

    int checks = 0;
    int errors = 0;

    phase_enc #(.STABLE_CYC(STABLE), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .D       (D),
        .ready   (ready),
        .err_clr (err_clr),
        .S       (S),
        .valid   (valid),
        .err     (err),
        .evt_cnt (evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs after a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic [7:0] d, input logic rdy, input logic clr);
        D = d; ready = rdy; err_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [2:0] s;
        logic       e;
        int         evt;
    } vec_t;

    vec_t vt[$];

    // Reference model: a reported change is a run of STABLE identical legal samples taken while no
    // report is outstanding, starting from a code that differs from the last one reported.
    int         m_run;
    logic [2:0] m_run_code, m_last, m_s;
    bit         m_have_last, m_pend, m_err;
    int         m_evt;

    task automatic model_reset();
        m_run = 0; m_run_code = 0; m_last = 0; m_s = 0;
        m_have_last = 0; m_pend = 0; m_err = 0; m_evt = 0;
    endtask

    task automatic model_edge(input logic [7:0] d, input logic rdy, input logic clr);
        int         n;
        logic [2:0] c;
        bit         lg, mh;
        n = $countones(d);
        c = 0;
        for (int i = 0; i < 8; i++) if (d[i]) c = i[2:0];
`ifdef PHASE_ENC_PRIORITY_EN
        lg = (n >= 1); mh = 0;
`else
        lg = (n == 1); mh = (n > 1);
`endif
        if (mh) m_err = 1;
        else if (clr) m_err = 0;
        if (m_pend) begin
            if (rdy) begin
                m_pend = 0;
                if (m_evt < EVT_MAX) m_evt++;
            end
        end else begin
            if (!lg) m_run = 0;
            else if (m_run > 0) begin
                if (c == m_run_code) m_run++;
                else begin m_run_code = c; m_run = 1; end
            end else if (!m_have_last || c != m_last) begin
                m_run_code = c; m_run = 1;
            end
            if (m_run == STABLE) begin
                m_pend = 1; m_s = m_run_code; m_last = m_run_code;
                m_have_last = 1; m_run = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; D = 8'h00; ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] rd;
        // Reset held with an active phase and ready asserted: outputs stay cleared.
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(8'h40, 1'b1, 1'b0);
            chk("rst_valid", valid, 0);
            chk("rst_S", S, 0);
            chk("rst_err", err, 0);
            chk("rst_evt", evt_cnt, 0);
        end
        reset_n = 1'b1;

        // basic (40 held), glitch (02 then 10), multi-hot and err set/clear priority
        vt.push_back('{8'h40, 1, 0, 0, 3'd0, 0, 0});
        vt.push_back('{8'h40, 1, 0, 1, 3'd6, 0, 0});
        vt.push_back('{8'h40, 1, 0, 0, 3'd0, 0, 1});
        vt.push_back('{8'h40, 1, 0, 0, 3'd0, 0, 1});
        vt.push_back('{8'h40, 1, 0, 0, 3'd0, 0, 1});
        vt.push_back('{8'h02, 1, 0, 0, 3'd0, 0, 1});
        vt.push_back('{8'h10, 1, 0, 0, 3'd0, 0, 1});
        vt.push_back('{8'h10, 1, 0, 1, 3'd4, 0, 1});
        vt.push_back('{8'h10, 1, 0, 0, 3'd0, 0, 2});
        vt.push_back('{8'h10, 1, 0, 0, 3'd0, 0, 2});
`ifdef PHASE_ENC_PRIORITY_EN
        vt.push_back('{8'h21, 1, 0, 0, 3'd0, 0, 2});
        vt.push_back('{8'h21, 1, 0, 1, 3'd5, 0, 2});
        vt.push_back('{8'h00, 1, 1, 0, 3'd0, 0, 3});
        vt.push_back('{8'h00, 1, 0, 0, 3'd0, 0, 3});
        vt.push_back('{8'h21, 1, 1, 0, 3'd0, 0, 3});
        vt.push_back('{8'h00, 1, 0, 0, 3'd0, 0, 3});
        vt.push_back('{8'h00, 1, 1, 0, 3'd0, 0, 3});
`else
        vt.push_back('{8'h21, 1, 0, 0, 3'd0, 1, 2});
        vt.push_back('{8'h21, 1, 0, 0, 3'd0, 1, 2});
        vt.push_back('{8'h00, 1, 1, 0, 3'd0, 0, 2});
        vt.push_back('{8'h00, 1, 0, 0, 3'd0, 0, 2});
        vt.push_back('{8'h21, 1, 1, 0, 3'd0, 1, 2});
        vt.push_back('{8'h00, 1, 0, 0, 3'd0, 1, 2});
        vt.push_back('{8'h00, 1, 1, 0, 3'd0, 0, 2});
`endif
        foreach (vt[i]) begin
            cyc(vt[i].d, vt[i].rdy, vt[i].clr);
            chk($sformatf("vec%0d_valid", i), valid, vt[i].v);
            chk($sformatf("vec%0d_err", i), err, vt[i].e);
            chk($sformatf("vec%0d_evt", i), evt_cnt, vt[i].evt);
            if (vt[i].v) chk($sformatf("vec%0d_S", i), S, vt[i].s);
        end

        // Backpressure: code 2 held through a D change, then 7 follows the handshake.
        do_reset();
        cyc(8'h04, 0, 0); chk("bp_settle_valid", valid, 0);
        cyc(8'h04, 0, 0); chk("bp_valid", valid, 1); chk("bp_S", S, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h80, 0, 0);
            chk("bp_hold_valid", valid, 1); chk("bp_hold_S", S, 2); chk("bp_hold_evt", evt_cnt, 0);
        end
        cyc(8'h80, 1, 0); chk("bp_hs_valid", valid, 0); chk("bp_hs_evt", evt_cnt, 1);
        cyc(8'h80, 1, 0); chk("bp_next_settle", valid, 0);
        cyc(8'h80, 1, 0); chk("bp_next_valid", valid, 1); chk("bp_next_S", S, 7);
        cyc(8'h80, 1, 0); chk("bp_next_evt", evt_cnt, 2); chk("bp_next_done", valid, 0);

        // Saturation: four alternating events on a 2-bit counter.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rd = 8'h01 << (k % 2);
            cyc(rd, 1, 0); chk("sat_settle", valid, 0);
            cyc(rd, 1, 0); chk("sat_valid", valid, 1); chk("sat_S", S, k % 2);
            cyc(rd, 1, 0); chk("sat_evt", evt_cnt, (k + 1 > 3) ? 3 : k + 1);
        end

        // Asynchronous reset while a report is pending.
        cyc(8'h08, 0, 0);
        cyc(8'h08, 0, 0); chk("mid_valid", valid, 1); chk("mid_S", S, 3);
        cyc(8'h21, 0, 0);
`ifndef PHASE_ENC_PRIORITY_EN
        chk("mid_err", err, 1);
`endif
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", valid, 0); chk("async_S", S, 0);
        chk("async_err", err, 0); chk("async_evt", evt_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized run against the model, with occasional asynchronous resets.
        do_reset();
        rd = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic rdy, clr;
            r = $urandom_range(0, 99);
            if (r < 55) rd = rd;
            else if (r < 80) rd = 8'h01 << $urandom_range(0, 7);
            else if (r < 88) rd = 8'h00;
            else rd = (8'h01 << $urandom_range(0, 3)) | (8'h10 << $urandom_range(0, 3));
            rdy = ($urandom_range(0, 99) < 65);
            clr = ($urandom_range(0, 99) < 10);
            D = rd; ready = rdy; err_clr = clr;
            @(posedge clk);
            model_edge(rd, rdy, clr);
            @(negedge clk);
            chk("rnd_valid", valid, m_pend);
            chk("rnd_err", err, m_err);
            chk("rnd_evt", evt_cnt, m_evt);
            if (m_pend) chk("rnd_S", S, m_s);
            if (n % 700 == 699) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rnd_async_valid", valid, 0);
                chk("rnd_async_evt", evt_cnt, 0);
                @(negedge clk);
                reset_n = 1'b1;
                model_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
